led_pwm_driver: RTL and testbench
=================================

# led_pwm_driver

Parametrised indicator driver for the board top levels. It takes per-channel activity bits (cog LEDs, reset and prop-plug status) from any source, synchronises them, and optionally stretches short pulses into visible blinks. Each channel is then dimmed by its own PWM duty level, replacing the fixed 1/8-duty "dim" AND-gating used per board. One instance drives every on-board LED of a board wrapper.

## Interface

- NUM_LEDS, 8, number of channels
- PWM_BITS, 3, PWM phase/duty width; period = 2^PWM_BITS clocks
- STRETCH_BITS, 20, activity hold counter width; hold = 2^STRETCH_BITS-1 clocks

- clock  in  1  single clock for all logic (board wrappers connect clock_160)
- nres  in  1  reset, asynchronous assert, active-low; the block contains no internal release synchroniser
- led_in  in  NUM_LEDS  raw indicator bits; may be asynchronous to clock
- level  in  NUM_LEDS*PWM_BITS  per-channel duty; channel i uses bits [i*PWM_BITS +: PWM_BITS]
- mode  in  2  mode[0]=dim enable, mode[1]=stretch enable; synchronous to clock
- led_out  out  NUM_LEDS  registered LED drive, active-high
- pwm_phase  out  PWM_BITS  current PWM phase, for sharing with other dimmed outputs

## Operation

- Reset (nres=0): all registers clear immediately. Cleared registers are the synchronisers, stretch counters, duty shadows, phase and led_out. Every output reads 0 while nres=0.
- Phase counter: increments every clock. It wraps from 2^PWM_BITS-1 to 0 with no stall.
- Duty shadow: per channel. Loads level[i] at the edge where phase==2^PWM_BITS-1, so a new duty takes effect from phase 0 of the next period. No mid-period glitches. The reset value is 0, so dimmed channels stay dark until the first wrap.
- pwm_on[i] = (phase < shadow[i]) as unsigned compare:
  - level 0 → never on.
  - level 2^PWM_BITS-1 → on for 2^PWM_BITS-1 of 2^PWM_BITS cycles.
- Synchroniser: two flops per channel, sync1 then sync2. No glitch filtering.
- Stretch counter, per channel, STRETCH_BITS wide:
  - next = sync2 ? all-ones : (cnt!=0 ? cnt-1 : 0).
  - The input being high has priority over decrement, so it reloads every cycle and never underflows.
- stretched[i] = sync2[i] | (cnt[i]!=0).
- active[i] = mode[1] ? stretched[i] : sync2[i].
- led_out[i] is registered as active[i] & (mode[0] ? pwm_on[i] : 1).
- Counters keep running regardless of mode. A mode change therefore takes effect on the next edge with no state reset.

## Timing

- Input latency: a led_in change setup before edge k appears on led_out after edge k+2 (sync1 at k, sync2 at k+1, output register at k+2). With dimming on, the bit is further masked by the pwm_on state at that cycle.
- Stretch: after sync2 falls, stretched stays high for exactly 2^STRETCH_BITS-1 further clocks.
  - Any input pulse of at least 1 clock seen on sync2 yields led_out high for ≥2^STRETCH_BITS clocks when mode[1]=1.
  - An input re-rising during the hold reloads the counter; the output never drops between the two events.
- PWM: with mode[0]=1 and active high, led_out is high on the cycles following edges where phase ∈ [0, shadow-1]. pwm_phase is the counter value itself, with zero latency.
- Reset mid-operation: led_out drops asynchronously. After release, the first phase increment occurs at the first clock edge, and stretch counters restart from 0.
- pwm_phase reset value 0. It reads 1 after the first edge following release.

## Test plan

- Reset: drive led_in all-ones, mode=00, then pulse nres low mid-run. Required: led_out=0 and pwm_phase=0 within the reset assertion, with no clock needed. After release, led_out=all-ones after 3 edges.
- Direct latency: mode=00, raise led_in[2] before edge k. Required: led_out[2] rises after edge k+2; other bits stay 0. Lowering it shows the same 3-edge latency.
- PWM duty: PWM_BITS=3, mode=01, led_in[0]=1, level ch0=3.
  - Required: after the first wrap, led_out[0] is high exactly 3 of every 8 cycles, aligned to phases 0–2.
  - Level 0 gives a constant 0; level 7 gives 7/8.
- Glitch-free level change: mode=01, change level ch0 from 2 to 6 while phase=4. Required: the current period keeps duty 2; the next period starts duty 6.
- Stretch: STRETCH_BITS=4, mode=10, one-clock pulse on led_in[5].
  - Required: led_out[5] high for 1+15=16 consecutive cycles, then 0.
  - A second pulse 10 cycles after the first extends the high time continuously.
- Stretch+dim: STRETCH_BITS=4, PWM_BITS=3, mode=11, level=1, single pulse. Required: led_out high only on phase-0 cycles during the 16-cycle hold window, and 0 afterwards.

Source files
------------

// File: rtl/led_pwm_driver.sv
// Multi-channel LED indicator driver: input synchronisers, activity pulse
// stretching and per-channel PWM dimming sharing one free-running phase counter.
module led_pwm_driver #(
   parameter int NUM_LEDS     = 8,
   parameter int PWM_BITS     = 3,
   parameter int STRETCH_BITS = 20
) (
   input  logic                         clock,
   input  logic                         nres,
   input  logic [NUM_LEDS-1:0]          led_in,
   input  logic [NUM_LEDS*PWM_BITS-1:0] level,
   input  logic [1:0]                   mode,
   output logic [NUM_LEDS-1:0]          led_out,
   output logic [PWM_BITS-1:0]          pwm_phase
);

   localparam logic [PWM_BITS-1:0]     PH_ONE  = {{(PWM_BITS-1){1'b0}}, 1'b1};
   localparam logic [STRETCH_BITS-1:0] CNT_ONE = {{(STRETCH_BITS-1){1'b0}}, 1'b1};

   logic [PWM_BITS-1:0]     phase_q, phase_d;
   logic [NUM_LEDS-1:0]     sync1_q, sync2_q;
   logic [NUM_LEDS-1:0]     led_q, led_d;
   logic [STRETCH_BITS-1:0] cnt_q    [NUM_LEDS];
   logic [STRETCH_BITS-1:0] cnt_d    [NUM_LEDS];
   logic [PWM_BITS-1:0]     shadow_q [NUM_LEDS];
   logic [PWM_BITS-1:0]     shadow_d [NUM_LEDS];
   logic                    wrap;
   logic [NUM_LEDS-1:0]     stretched, active, pwm_on;

   always_comb begin
      phase_d   = phase_q + PH_ONE;
      wrap      = &phase_q;
      stretched = '0;
      active    = '0;
      pwm_on    = '0;
      led_d     = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         // Duty is only sampled on the last phase so a period never changes mid-way.
         shadow_d[i] = wrap ? level[i*PWM_BITS +: PWM_BITS] : shadow_q[i];
         if (sync2_q[i])
            cnt_d[i] = '1;
         else if (cnt_q[i] != '0)
            cnt_d[i] = cnt_q[i] - CNT_ONE;
         else
            cnt_d[i] = cnt_q[i];
         stretched[i] = sync2_q[i] | (cnt_q[i] != '0);
         active[i]    = mode[1] ? stretched[i] : sync2_q[i];
         pwm_on[i]    = (phase_q < shadow_q[i]);
         led_d[i]     = active[i] & (mode[0] ? pwm_on[i] : 1'b1);
      end
   end

   always_ff @(posedge clock or negedge nres) begin
      if (!nres) begin
         phase_q  <= '0;
         sync1_q  <= '0;
         sync2_q  <= '0;
         led_q    <= '0;
         cnt_q    <= '{default: '0};
         shadow_q <= '{default: '0};
      end else begin
         phase_q  <= phase_d;
         sync1_q  <= led_in;
         sync2_q  <= sync1_q;
         led_q    <= led_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
      end
   end

   assign led_out   = led_q;
   assign pwm_phase = phase_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Randomised and directed bench for led_pwm_driver against an edge-indexed
// history model of the input, duty shadow and phase.
module tb_led_pwm_driver;

   localparam int NL   = 8;
   localparam int PB   = 3;
   localparam int SB   = 4;
   localparam int PER  = 1 << PB;
   localparam int HOLD = (1 << SB) - 1;

   logic              clock = 1'b0;
   logic              nres;
   logic [NL-1:0]     led_in;
   logic [NL*PB-1:0]  level;
   logic [1:0]        mode;
   logic [NL-1:0]     led_out;
   logic [PB-1:0]     pwm_phase;

   int errors = 0;
   int checks = 0;

   // Model state: input value driven before each edge since release.
   logic [NL-1:0] hist[$];
   int            t;
   int            shadow_m [NL];
   int            cnt_hi;

   led_pwm_driver #(.NUM_LEDS(NL), .PWM_BITS(PB), .STRETCH_BITS(SB)) dut (
      .clock(clock), .nres(nres), .led_in(led_in), .level(level),
      .mode(mode), .led_out(led_out), .pwm_phase(pwm_phase)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NL-1:0] in_at(input int n);
      if (n < 0) return '0;
      return hist[n];
   endfunction

   task automatic model_reset();
      hist.delete();
      t = 0;
      for (int c = 0; c < NL; c++) shadow_m[c] = 0;
   endtask

   task automatic step(input logic [NL-1:0] li, input logic [NL*PB-1:0] lv, input logic [1:0] md);
      logic [NL-1:0] e, s2, st, v;
      int ph;
      led_in = li;
      level  = lv;
      mode   = md;
      ph = t % PER;
      s2 = in_at(t - 2);
      st = '0;
      for (int j = 0; j <= HOLD; j++) begin
         v  = in_at(t - 2 - j);
         st = st | v;
      end
      for (int c = 0; c < NL; c++)
         e[c] = (md[1] ? st[c] : s2[c]) & (md[0] ? (ph < shadow_m[c]) : 1'b1);
      @(posedge clock);
      #1;
      hist.push_back(li);
      if (ph == PER - 1)
         for (int c = 0; c < NL; c++) shadow_m[c] = int'(lv[c*PB +: PB]);
      t++;
      check("led_out", 32'(led_out), 32'(e));
      check("pwm_phase", 32'(pwm_phase), 32'(t % PER));
   endtask

   initial begin
      nres   = 1'b0;
      led_in = '0;
      level  = '0;
      mode   = 2'b00;
      model_reset();
      #12;
      check("reset_led_out", 32'(led_out), 32'h0);
      check("reset_phase", 32'(pwm_phase), 32'h0);
      nres = 1'b1;

      // Direct latency on channel 2
      for (int k = 0; k < 3; k++) step(8'h00, '0, 2'b00);
      for (int k = 0; k < 4; k++) step(8'h04, '0, 2'b00);
      for (int k = 0; k < 4; k++) step(8'h00, '0, 2'b00);

      // PWM duty 3, 0 and 7 on channel 0
      for (int k = 0; k < 16; k++) step(8'h01, 24'd3, 2'b01);
      cnt_hi = 0;
      for (int k = 0; k < PER; k++) begin
         step(8'h01, 24'd3, 2'b01);
         cnt_hi += int'(led_out[0]);
      end
      check("duty3_count", 32'(cnt_hi), 32'd3);
      for (int k = 0; k < 16; k++) step(8'h01, 24'd0, 2'b01);
      cnt_hi = 0;
      for (int k = 0; k < PER; k++) begin
         step(8'h01, 24'd0, 2'b01);
         cnt_hi += int'(led_out[0]);
      end
      check("duty0_count", 32'(cnt_hi), 32'd0);
      for (int k = 0; k < 16; k++) step(8'h01, 24'd7, 2'b01);
      cnt_hi = 0;
      for (int k = 0; k < PER; k++) begin
         step(8'h01, 24'd7, 2'b01);
         cnt_hi += int'(led_out[0]);
      end
      check("duty7_count", 32'(cnt_hi), 32'd7);

      // Level change 2 -> 6 in the middle of a period
      for (int k = 0; k < 16; k++) step(8'h01, 24'd2, 2'b01);
      while ((t % PER) != 4) step(8'h01, 24'd2, 2'b01);
      for (int k = 0; k < 20; k++) step(8'h01, 24'd6, 2'b01);

      // Single-clock pulse stretched on channel 5
      for (int k = 0; k < 20; k++) step(8'h00, '0, 2'b10);
      cnt_hi = 0;
      step(8'h20, '0, 2'b10);
      for (int k = 0; k < 26; k++) begin
         step(8'h00, '0, 2'b10);
         cnt_hi += int'(led_out[5]);
      end
      check("stretch_len", 32'(cnt_hi), 32'd16);
      step(8'h20, '0, 2'b10);
      for (int k = 0; k < 9; k++) step(8'h00, '0, 2'b10);
      step(8'h20, '0, 2'b10);
      for (int k = 0; k < 30; k++) step(8'h00, '0, 2'b10);

      // Stretch plus dim at level 1
      for (int k = 0; k < 16; k++) step(8'h00, {NL{3'd1}}, 2'b11);
      step(8'h20, {NL{3'd1}}, 2'b11);
      for (int k = 0; k < 26; k++) step(8'h00, {NL{3'd1}}, 2'b11);

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 15) == 0) level = 24'($urandom);
         step(($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00, level, 2'($urandom));
      end

      // Asynchronous reset in the middle of a run
      for (int k = 0; k < 6; k++) step(8'hff, level, 2'b00);
      nres = 1'b0;
      #1;
      check("async_rst_led_out", 32'(led_out), 32'h0);
      check("async_rst_phase", 32'(pwm_phase), 32'h0);
      @(posedge clock);
      @(posedge clock);
      #1;
      check("held_rst_led_out", 32'(led_out), 32'h0);
      nres = 1'b1;
      model_reset();
      for (int k = 0; k < 3; k++) step(8'hff, level, 2'b00);
      check("post_rst_all_on", 32'(led_out), 32'hff);
      for (int k = 0; k < 10; k++) step(8'hff, level, 2'b00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
